alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003: flush  input  1  kill the held entry; no capture in the same cycle.
REQ-004: in_valid  input  1  upstream instruction valid.
REQ-005: in_ready  output  1  issue register can accept an instruction.
REQ-006: inst  input  32  RV32I instruction word.
REQ-007: pc  input  32  instruction address.
REQ-008: rs1_data, rs2_data  input  32 each  register-file read data.
REQ-009: out_valid  output  1  held entry valid toward the ALU stage.
REQ-010: out_ready  input  1  ALU stage consumes the held entry this cycle.
REQ-011: alu_a, alu_b  output  32 each  registered ALU operands.
REQ-012: aluop  output  4  registered ALU operation code.
REQ-013: rd  output  5  destination register, inst[11:7].
REQ-014: reg_we  output  1  entry writes rd.
REQ-015: illegal  output  1  entry carries an unsupported opcode.

Function
REQ-016: aluop encoding SHALL be ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRA=8, SRL=9, COPY_B=10, XXX=15.
REQ-017: in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-018: Capture SHALL occur when in_valid && in_ready: all outputs load the decoded fields and out_valid=1 the next cycle.
REQ-019: When out_valid && out_ready && no capture occurs, out_valid SHALL go to 0 the next cycle; data outputs hold their values.
REQ-020: When out_valid && !out_ready, all outputs SHALL hold unchanged, regardless of the upstream inputs.
REQ-021: flush SHALL force out_valid=0 the next cycle and SHALL take priority over capture and hold.
REQ-022: Latency SHALL be 1 cycle from capture to out_valid; throughput SHALL be 1 instruction/cycle when out_ready stays high.
REQ-023: OP (0110011): A=rs1, B=rs2; funct3/funct7[5] select ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND; reg_we=1.
REQ-024: OP-IMM (0010011): A=rs1, B=sign-extended imm_I; same funct3 map with ADD only; funct7[5] selects SRA for funct3=101 only; B[4:0]=shamt; reg_we=1.
REQ-025: LUI: A=0, B={inst[31:12],12'b0}, COPY_B; AUIPC: A=pc, B=imm_U, ADD; reg_we=1 for both.
REQ-026: LOAD: A=rs1, B=imm_I, ADD, reg_we=1. STORE: A=rs1, B=imm_S, ADD, reg_we=0.
REQ-027: BRANCH: A=pc, B=imm_B (bit0=0), ADD, reg_we=0.
REQ-028: JAL: A=pc, B=imm_J, ADD, reg_we=1. JALR: A=rs1, B=imm_I, ADD, reg_we=1. The link value (pc+4) is formed downstream.
REQ-029: Any other opcode SHALL yield aluop=XXX, illegal=1, reg_we=0, A=0 and B=0, and the entry SHALL still handshake normally.
REQ-030: rd=0 SHALL force reg_we=0.
REQ-031: All immediates SHALL be sign-extended from inst[31]; all arithmetic is 32-bit, with no carries retained.

Reset
REQ-032: While reset is high at a clock edge: out_valid=0, alu_a=0, alu_b=0, aluop=XXX, rd=0, reg_we=0, illegal=0.
REQ-033: Reset SHALL override flush, capture and hold; an entry held when reset asserts SHALL be discarded.
REQ-034: in_ready SHALL be 1 in the cycle after reset deasserts, provided flush=0.

Verification
REQ-035: ADD x3,x1,x2 (inst 0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle: out_valid=1, A=5, B=7, aluop=0, rd=3, reg_we=1.
REQ-036: SRAI x1,x1,3 (0x4030D093) -> aluop=8, B=3. ADDI x1,x0,-1 (0xFFF00093) -> B=0xFFFFFFFF, aluop=0.
REQ-037: Back-to-back stream of 4 instructions with out_ready=0 for 2 cycles mid-stream -> outputs stable during the stall, in_ready=0, no instruction lost or duplicated, order preserved.
REQ-038: flush=1 with in_valid=1 while an entry is held -> next cycle out_valid=0, the new instruction is not captured, and in_ready=0 during the flush cycle.
REQ-039: inst=0xFFFFFFFF -> illegal=1, aluop=15, reg_we=0, out_valid=1. LUI x5,0x12345 (0x123452B7) -> B=0x12345000, aluop=10.
REQ-040: Reset asserted while out_valid=1 and out_ready=0 -> next cycle all outputs are at the REQ-032 values.

Source files
------------

// File: rtl/alu_issue_if.sv
// Issue-stage handshake bundle: upstream instruction/operand side plus registered ALU-facing side.
// slave is the issue register's view, master is the producer/consumer (bench or neighbouring stages).
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic        reg_we;
    logic        illegal;

    modport slave (
        input  in_valid, inst, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_a, alu_b, aluop, rd, reg_we, illegal
    );

    modport master (
        output in_valid, inst, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, aluop, rd, reg_we, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I issue register: decodes operands/aluop into a single held entry, 1-cycle capture-to-valid latency.
// Holds while out_ready is low (in_ready drops); flush kills the entry and blocks capture that cycle.
module alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    alu_issue_if.slave  io
);
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLTU   = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRA    = 4'd8;
    localparam logic [3:0] ALU_SRL    = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd10;
    localparam logic [3:0] ALU_XXX    = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [4:0]  dec_rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] shamt;

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_op;
    logic        dec_we;
    logic        dec_ill;

    logic        in_ready;
    logic        capture;

    logic        out_valid_q, out_valid_d;
    logic [31:0] alu_a_q,     alu_a_d;
    logic [31:0] alu_b_q,     alu_b_d;
    logic [3:0]  aluop_q,     aluop_d;
    logic [4:0]  rd_q,        rd_d;
    logic        reg_we_q,    reg_we_d;
    logic        illegal_q,   illegal_d;

    assign opcode    = io.inst[6:0];
    assign funct3    = io.inst[14:12];
    assign funct7_b5 = io.inst[30];
    assign dec_rd    = io.inst[11:7];

    assign imm_i = {{20{io.inst[31]}}, io.inst[31:20]};
    assign imm_s = {{20{io.inst[31]}}, io.inst[31:25], io.inst[11:7]};
    assign imm_b = {{19{io.inst[31]}}, io.inst[31], io.inst[7], io.inst[30:25], io.inst[11:8], 1'b0};
    assign imm_u = {io.inst[31:12], 12'b0};
    assign imm_j = {{11{io.inst[31]}}, io.inst[31], io.inst[19:12], io.inst[20], io.inst[30:21], 1'b0};
    // Immediate shifts carry only the shift amount; funct7 bits must not leak into B.
    assign shamt = {27'b0, io.inst[24:20]};

    always_comb begin
        dec_a   = '0;
        dec_b   = '0;
        dec_op  = ALU_XXX;
        dec_we  = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a  = io.rs1_data;
                dec_b  = io.rs2_data;
                dec_we = 1'b1;
                case (funct3)
                    3'b000:  dec_op = funct7_b5 ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_op = ALU_SLL;
                    3'b010:  dec_op = ALU_SLT;
                    3'b011:  dec_op = ALU_SLTU;
                    3'b100:  dec_op = ALU_XOR;
                    3'b101:  dec_op = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_op = ALU_OR;
                    default: dec_op = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                dec_a  = io.rs1_data;
                dec_b  = imm_i;
                dec_we = 1'b1;
                case (funct3)
                    3'b000:  dec_op = ALU_ADD;
                    3'b001: begin
                        dec_op = ALU_SLL;
                        dec_b  = shamt;
                    end
                    3'b010:  dec_op = ALU_SLT;
                    3'b011:  dec_op = ALU_SLTU;
                    3'b100:  dec_op = ALU_XOR;
                    3'b101: begin
                        dec_op = funct7_b5 ? ALU_SRA : ALU_SRL;
                        dec_b  = shamt;
                    end
                    3'b110:  dec_op = ALU_OR;
                    default: dec_op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec_b  = imm_u;
                dec_op = ALU_COPY_B;
                dec_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a  = io.pc;
                dec_b  = imm_u;
                dec_op = ALU_ADD;
                dec_we = 1'b1;
            end
            OPC_LOAD: begin
                dec_a  = io.rs1_data;
                dec_b  = imm_i;
                dec_op = ALU_ADD;
                dec_we = 1'b1;
            end
            OPC_STORE: begin
                dec_a  = io.rs1_data;
                dec_b  = imm_s;
                dec_op = ALU_ADD;
            end
            OPC_BRANCH: begin
                dec_a  = io.pc;
                dec_b  = imm_b;
                dec_op = ALU_ADD;
            end
            OPC_JAL: begin
                dec_a  = io.pc;
                dec_b  = imm_j;
                dec_op = ALU_ADD;
                dec_we = 1'b1;
            end
            OPC_JALR: begin
                dec_a  = io.rs1_data;
                dec_b  = imm_i;
                dec_op = ALU_ADD;
                dec_we = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
        // x0 is never written, whatever the opcode says.
        if (dec_rd == 5'd0) begin
            dec_we = 1'b0;
        end
    end

    assign in_ready = (!out_valid_q || io.out_ready) && !flush;
    assign capture  = io.in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        aluop_d     = aluop_q;
        rd_d        = rd_q;
        reg_we_d    = reg_we_q;
        illegal_d   = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            alu_a_d     = dec_a;
            alu_b_d     = dec_b;
            aluop_d     = dec_op;
            rd_d        = dec_rd;
            reg_we_d    = dec_we;
            illegal_d   = dec_ill;
        end else if (out_valid_q && io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            aluop_q     <= ALU_XXX;
            rd_q        <= '0;
            reg_we_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            aluop_q     <= aluop_d;
            rd_q        <= rd_d;
            reg_we_q    <= reg_we_d;
            illegal_q   <= illegal_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.alu_a     = alu_a_q;
    assign io.alu_b     = alu_b_q;
    assign io.aluop     = aluop_q;
    assign io.rd        = rd_q;
    assign io.reg_we    = reg_we_q;
    assign io.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed RV32I cases plus random traffic against a cycle-level reference model.
module tb_alu_issue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    alu_issue_if bus();

    alu_issue dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .io    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } entry_t;

    localparam logic [75:0] RST_VEC = {1'b0, 32'd0, 32'd0, 4'd15, 5'd0, 1'b0, 1'b0};

    int     checks   = 0;
    int     failures = 0;
    logic   m_valid;
    entry_t m_e;
    logic   m_rdy;
    logic   obs_rdy;
    entry_t cons_q[$];

    function automatic entry_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                          input logic [31:0] rs1, input logic [31:0] rs2);
        entry_t e;
        logic signed [31:0] t;
        logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, op_map;
        logic [2:0]  f3;
        f3     = inst[14:12];
        op_map = {4'd2, 4'd3, 4'd9, 4'd4, 4'd6, 4'd5, 4'd7, 4'd0};
        t = inst;                                                  imm_i = t >>> 20;
        t = {inst[31:25], inst[11:7], 20'b0};                      imm_s = t >>> 20;
        t = {inst[31], inst[7], inst[30:25], inst[11:8], 20'b0};   imm_b = t >>> 19;
        t = {inst[31], inst[19:12], inst[20], inst[30:21], 12'b0}; imm_j = t >>> 11;
        imm_u = inst & 32'hFFFF_F000;
        e = '{a: 32'd0, b: 32'd0, op: 4'd15, rd: inst[11:7], we: 1'b0, ill: 1'b0};
        case (inst[6:0])
            7'b0110011: begin
                e.a = rs1; e.b = rs2; e.we = 1'b1;
                e.op = op_map[{f3, 2'b00} +: 4];
                if (inst[30] && f3 == 3'd0) e.op = 4'd1;
                if (inst[30] && f3 == 3'd5) e.op = 4'd8;
            end
            7'b0010011: begin
                e.a = rs1; e.we = 1'b1;
                e.op = op_map[{f3, 2'b00} +: 4];
                if (inst[30] && f3 == 3'd5) e.op = 4'd8;
                e.b = (f3 == 3'd1 || f3 == 3'd5) ? 32'(inst[24:20]) : imm_i;
            end
            7'b0110111: begin e.b = imm_u; e.op = 4'd10; e.we = 1'b1; end
            7'b0010111: begin e.a = pc;  e.b = imm_u; e.op = 4'd0; e.we = 1'b1; end
            7'b0000011: begin e.a = rs1; e.b = imm_i; e.op = 4'd0; e.we = 1'b1; end
            7'b0100011: begin e.a = rs1; e.b = imm_s; e.op = 4'd0; end
            7'b1100011: begin e.a = pc;  e.b = imm_b; e.op = 4'd0; end
            7'b1101111: begin e.a = pc;  e.b = imm_j; e.op = 4'd0; e.we = 1'b1; end
            7'b1100111: begin e.a = rs1; e.b = imm_i; e.op = 4'd0; e.we = 1'b1; end
            default:    e.ill = 1'b1;
        endcase
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rand_legal_inst();
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom();
        case ($urandom_range(0, 8))
            0: opc = 7'b0110011;
            1: opc = 7'b0010011;
            2: opc = 7'b0110111;
            3: opc = 7'b0010111;
            4: opc = 7'b0000011;
            5: opc = 7'b0100011;
            6: opc = 7'b1100011;
            7: opc = 7'b1101111;
            default: opc = 7'b1100111;
        endcase
        return {r[31:7], opc};
    endfunction

    function automatic logic [31:0] rand_inst();
        if ($urandom_range(0, 7) == 0) return $urandom();
        return rand_legal_inst();
    endfunction

    function automatic logic [75:0] dut_vec();
        return {bus.out_valid, bus.alu_a, bus.alu_b, bus.aluop, bus.rd, bus.reg_we, bus.illegal};
    endfunction

    // One clock: sample handshake just before the edge, advance the reference model, land on the next negedge.
    task automatic tick();
        #1;
        obs_rdy = bus.in_ready;
        m_rdy   = (!m_valid || bus.out_ready) && !flush;
        if (!reset && !flush && bus.out_valid && bus.out_ready)
            cons_q.push_back({bus.alu_a, bus.alu_b, bus.aluop, bus.rd, bus.reg_we, bus.illegal});
        if (reset) begin
            m_valid = 1'b0;
            m_e = '{a: 32'd0, b: 32'd0, op: 4'd15, rd: 5'd0, we: 1'b0, ill: 1'b0};
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (bus.in_valid && m_rdy) begin
            m_valid = 1'b1;
            m_e = ref_decode(bus.inst, bus.pc, bus.rs1_data, bus.rs2_data);
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid = v; bus.inst = inst; bus.pc = pc; bus.rs1_data = rs1; bus.rs2_data = rs2;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h100, 32'd1, 32'd2);
        tick(); tick();
        checks++;
        if (dut_vec() !== RST_VEC) begin
            failures++; $display("FAIL reset_state: got %h expected %h", dut_vec(), RST_VEC);
        end
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ti[7], tp[7], t1[7], t2[7];
        logic [75:0] te[7];
        ti[0] = 32'h002081B3; tp[0] = 32'h0;    t1[0] = 32'd5;         t2[0] = 32'd7;
        te[0] = {1'b1, 32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 1'b0};
        ti[1] = 32'h4030D093; tp[1] = 32'h0;    t1[1] = 32'h8000_0000; t2[1] = 32'h55;
        te[1] = {1'b1, 32'h8000_0000, 32'd3, 4'd8, 5'd1, 1'b1, 1'b0};
        ti[2] = 32'hFFF00093; tp[2] = 32'h0;    t1[2] = 32'd0;         t2[2] = 32'h99;
        te[2] = {1'b1, 32'd0, 32'hFFFF_FFFF, 4'd0, 5'd1, 1'b1, 1'b0};
        ti[3] = 32'hFFFFFFFF; tp[3] = 32'h40;   t1[3] = 32'h1234;      t2[3] = 32'h5678;
        te[3] = {1'b1, 32'd0, 32'd0, 4'd15, 5'd31, 1'b0, 1'b1};
        ti[4] = 32'h123452B7; tp[4] = 32'h80;   t1[4] = 32'hDEAD;      t2[4] = 32'hBEEF;
        te[4] = {1'b1, 32'd0, 32'h1234_5000, 4'd10, 5'd5, 1'b1, 1'b0};
        ti[5] = 32'h00208033; tp[5] = 32'h0;    t1[5] = 32'd1;         t2[5] = 32'd2;
        te[5] = {1'b1, 32'd1, 32'd2, 4'd0, 5'd0, 1'b0, 1'b0};
        ti[6] = 32'hFE000EE3; tp[6] = 32'h1000; t1[6] = 32'd3;         t2[6] = 32'd4;
        te[6] = {1'b1, 32'h1000, 32'hFFFF_FFFC, 4'd0, 5'd29, 1'b0, 1'b0};
        bus.out_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ti[i], tp[i], t1[i], t2[i]);
            tick();
            checks++;
            if (dut_vec() !== te[i]) begin
                failures++; $display("FAIL directed_%0d: got %h expected %h", i, dut_vec(), te[i]);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rand_inst(), $urandom(), $urandom(), $urandom());
            bus.out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 9) == 0;
            tick();
            checks++;
            if (obs_rdy !== m_rdy) begin
                failures++; $display("FAIL random_in_ready[%0d]: got %b expected %b", i, obs_rdy, m_rdy);
            end
            checks++;
            if (dut_vec() !== {m_valid, m_e}) begin
                failures++; $display("FAIL random_out[%0d]: got %h expected %h", i, dut_vec(), {m_valid, m_e});
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] li[4], lp[4], l1[4], l2[4];
        logic [75:0] pre;
        int idx;
        flush = 1'b1; bus.out_ready = 1'b1; drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        flush = 1'b0;
        cons_q.delete();
        for (int i = 0; i < 4; i++) begin
            li[i] = rand_legal_inst(); lp[i] = $urandom(); l1[i] = $urandom(); l2[i] = $urandom();
        end
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            bus.out_ready = !(c == 2 || c == 3);
            if (idx < 4) drive(1'b1, li[idx], lp[idx], l1[idx], l2[idx]);
            else         drive(1'b0, $urandom(), $urandom(), $urandom(), $urandom());
            pre = dut_vec();
            tick();
            if (bus.in_valid && m_rdy) idx++;
            if (c == 2 || c == 3) begin
                checks++;
                if (obs_rdy !== 1'b0) begin
                    failures++; $display("FAIL b2b_stall_in_ready[%0d]: got %b expected 0", c, obs_rdy);
                end
                checks++;
                if (dut_vec() !== pre) begin
                    failures++; $display("FAIL b2b_stall_hold[%0d]: got %h expected %h", c, dut_vec(), pre);
                end
            end
        end
        checks++;
        if (cons_q.size() != 4) begin
            failures++; $display("FAIL b2b_count: got %0d expected 4", cons_q.size());
        end
        for (int i = 0; i < 4 && i < cons_q.size(); i++) begin
            checks++;
            if (cons_q[i] !== ref_decode(li[i], lp[i], l1[i], l2[i])) begin
                failures++;
                $display("FAIL b2b_order[%0d]: got %h expected %h", i, cons_q[i], ref_decode(li[i], lp[i], l1[i], l2[i]));
            end
        end
    endtask

    task automatic test_flush();
        entry_t held;
        flush = 1'b0; bus.out_ready = 1'b1; drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h200, 32'd5, 32'd7);
        held = ref_decode(32'h002081B3, 32'h200, 32'd5, 32'd7);
        tick();
        checks++;
        if (dut_vec() !== {1'b1, held}) begin
            failures++; $display("FAIL flush_setup: got %h expected %h", dut_vec(), {1'b1, held});
        end
        flush = 1'b1;
        drive(1'b1, 32'hFFFFFFFF, 32'h300, 32'd9, 32'd9);
        tick();
        checks++;
        if (obs_rdy !== 1'b0) begin
            failures++; $display("FAIL flush_in_ready: got %b expected 0", obs_rdy);
        end
        checks++;
        if (dut_vec() !== {1'b0, held}) begin
            failures++; $display("FAIL flush_kill: got %h expected %h", dut_vec(), {1'b0, held});
        end
        flush = 1'b0; bus.out_ready = 1'b1; drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || obs_rdy !== 1'b1) begin
            failures++; $display("FAIL flush_after: got valid=%b rdy=%b expected valid=0 rdy=1", bus.out_valid, obs_rdy);
        end
    endtask

    task automatic test_reset_hold();
        bus.out_ready = 1'b0; flush = 1'b0;
        drive(1'b1, 32'h123452B7, 32'h400, 32'd1, 32'd2);
        tick(); tick();
        checks++;
        if (dut_vec() !== {1'b1, ref_decode(32'h123452B7, 32'h400, 32'd1, 32'd2)}) begin
            failures++; $display("FAIL rsthold_setup: got %h", dut_vec());
        end
        reset = 1'b1; flush = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== RST_VEC) begin
            failures++; $display("FAIL rsthold_clear: got %h expected %h", dut_vec(), RST_VEC);
        end
        reset = 1'b0; flush = 1'b0; drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL rsthold_in_ready: got %b expected 1", bus.in_ready);
        end
        tick();
    endtask

    initial begin
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
